// File: rtl/btb_ras_predictor.sv
// Direct-mapped dual-slot BTB with speculative and committed return stacks.
// Lookup is combinational; training, RAS updates and repair are synchronous.
module btb_ras_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            fetch_valid,
  input  logic            mispredict,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_call,
  input  logic            upd_is_ret,
  output logic            btb_hit1,
  output logic            btb_hit2,
  output logic [XLEN-1:0] pred_target1,
  output logic [XLEN-1:0] pred_target2,
  output logic            is_ret1,
  output logic            is_ret2,
  output logic [XLEN-1:0] ret_addr1,
  output logic [XLEN-1:0] ret_addr2
);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [BTB_ENTRIES-1:0] bv, bcall, bret;
  logic [TW-1:0]   btag [BTB_ENTRIES];
  logic [XLEN-1:0] btgt [BTB_ENTRIES];

  logic [XLEN-1:0] smem [RAS_DEPTH];
  logic [XLEN-1:0] cmem [RAS_DEPTH];
  logic [PW-1:0]   sptr, cptr, sptr_n, cptr_n;
  logic [PW:0]     scnt, ccnt, scnt_n, ccnt_n;

  logic [XLEN-1:0] a2;
  logic [IW-1:0]   i1, i2, ui;
  logic [TW-1:0]   t1, t2, ut;
  logic            sempty;
  logic            sel_call, sel_ret;
  logic [XLEN-1:0] sel_addr, s_val, c_val;
  logic            s_push, s_pop, c_push, c_pop;

  assign a2 = pc + XLEN'(4);
  assign i1 = pc[IW+1:2];
  assign t1 = pc[XLEN-1:IW+2];
  assign i2 = a2[IW+1:2];
  assign t2 = a2[XLEN-1:IW+2];
  assign ui = upd_pc[IW+1:2];
  assign ut = upd_pc[XLEN-1:IW+2];

  assign btb_hit1 = bv[i1] && (btag[i1] == t1);
  assign btb_hit2 = bv[i2] && (btag[i2] == t2);
  assign pred_target1 = btb_hit1 ? btgt[i1] : '0;
  assign pred_target2 = btb_hit2 ? btgt[i2] : '0;

  assign sempty    = (scnt == '0);
  assign ret_addr1 = sempty ? '0 : smem[sptr];
  assign ret_addr2 = ret_addr1;
  assign is_ret1   = btb_hit1 && bret[i1] && !sempty;
  assign is_ret2   = btb_hit2 && bret[i2] && !sempty;

  // Slot 1 wins, matching the PC register's priority.
  assign sel_call = btb_hit1 ? bcall[i1] : (btb_hit2 && bcall[i2]);
  assign sel_ret  = btb_hit1 ? bret[i1]  : (btb_hit2 && bret[i2]);
  assign sel_addr = btb_hit1 ? pc : a2;
  assign s_val    = sel_addr + XLEN'(4);
  assign c_val    = upd_pc + XLEN'(4);

  assign s_push = fetch_valid && !mispredict && sel_call;
  assign s_pop  = fetch_valid && !mispredict && !sel_call && sel_ret;
  assign c_push = upd_valid && upd_is_call;
  assign c_pop  = upd_valid && !upd_is_call && upd_is_ret;

  always_comb begin
    sptr_n = sptr;
    scnt_n = scnt;
    if (s_push) begin
      sptr_n = sptr + PW'(1);
      scnt_n = (scnt == FULL) ? scnt : scnt + 1'b1;
    end else if (s_pop && !sempty) begin
      sptr_n = sptr - PW'(1);
      scnt_n = scnt - 1'b1;
    end
  end

  always_comb begin
    cptr_n = cptr;
    ccnt_n = ccnt;
    if (c_push) begin
      cptr_n = cptr + PW'(1);
      ccnt_n = (ccnt == FULL) ? ccnt : ccnt + 1'b1;
    end else if (c_pop && ccnt != '0) begin
      cptr_n = cptr - PW'(1);
      ccnt_n = ccnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      bv   <= '0;
      sptr <= '0;
      scnt <= '0;
      cptr <= '0;
      ccnt <= '0;
    end else begin
      if (upd_valid) begin
        if (upd_taken) begin
          bv[ui]    <= 1'b1;
          btag[ui]  <= ut;
          btgt[ui]  <= upd_target;
          bcall[ui] <= upd_is_call;
          bret[ui]  <= upd_is_ret;
        end else if (btag[ui] == ut) begin
          bv[ui] <= 1'b0;
        end
      end
      cptr <= cptr_n;
      ccnt <= ccnt_n;
      if (c_push) cmem[cptr_n] <= c_val;
      // Repair copies the committed stack as it stands after this cycle's update.
      if (mispredict) begin
        sptr <= cptr_n;
        scnt <= ccnt_n;
        for (int i = 0; i < RAS_DEPTH; i++)
          smem[i] <= (c_push && cptr_n == PW'(i)) ? c_val : cmem[i];
      end else begin
        sptr <= sptr_n;
        scnt <= scnt_n;
        if (s_push) smem[sptr_n] <= s_val;
      end
    end
  end
endmodule

// File: tb/tb_btb_ras_predictor.sv
// Directed table-driven bench for btb_ras_predictor.
// Each vector drives one cycle and checks the pre-edge outputs.
module tb_btb_ras_predictor;
  logic        CLK = 0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_valid, mispredict;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken, upd_is_call, upd_is_ret;
  logic        btb_hit1, btb_hit2, is_ret1, is_ret2;
  logic [31:0] pred_target1, pred_target2, ret_addr1, ret_addr2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btb_ras_predictor dut (
    .CLK(CLK), .reset(reset), .pc(pc),
    .fetch_valid(fetch_valid), .mispredict(mispredict),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret),
    .btb_hit1(btb_hit1), .btb_hit2(btb_hit2),
    .pred_target1(pred_target1), .pred_target2(pred_target2),
    .is_ret1(is_ret1), .is_ret2(is_ret2),
    .ret_addr1(ret_addr1), .ret_addr2(ret_addr2)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv, mp, uv;
    logic [31:0] upc, utgt;
    logic        utk, ucall, uret;
    logic        h1, h2;
    logic [31:0] t1, t2;
    logic        r1, r2;
    logic [31:0] ra;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    string n, logic [31:0] p, logic fv, logic mp,
    logic uv, logic [31:0] upc, logic [31:0] utgt,
    logic utk, logic ucall, logic uret,
    logic h1, logic h2, logic [31:0] t1, logic [31:0] t2,
    logic r1, logic r2, logic [31:0] ra);
    vec_t v;
    v.name = n; v.pc = p; v.fv = fv; v.mp = mp;
    v.uv = uv; v.upc = upc; v.utgt = utgt;
    v.utk = utk; v.ucall = ucall; v.uret = uret;
    v.h1 = h1; v.h2 = h2; v.t1 = t1; v.t2 = t2;
    v.r1 = r1; v.r2 = r2; v.ra = ra;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [131:0] act, exp;
    @(negedge CLK);
    pc = v.pc; fetch_valid = v.fv; mispredict = v.mp;
    upd_valid = v.uv; upd_pc = v.upc; upd_target = v.utgt;
    upd_taken = v.utk; upd_is_call = v.ucall; upd_is_ret = v.uret;
    #1;
    act = {btb_hit1, btb_hit2, pred_target1, pred_target2,
           is_ret1, is_ret2, ret_addr1, ret_addr2};
    exp = {v.h1, v.h2, v.t1, v.t2, v.r1, v.r2, v.ra, v.ra};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: h=%b%b t1=%h t2=%h r=%b%b ra=%h/%h want h=%b%b t1=%h t2=%h r=%b%b ra=%h",
        v.name, btb_hit1, btb_hit2, pred_target1, pred_target2,
        is_ret1, is_ret2, ret_addr1, ret_addr2,
        v.h1, v.h2, v.t1, v.t2, v.r1, v.r2, v.ra);
    end
  endtask

  task automatic do_reset(input logic [31:0] upc);
    @(negedge CLK);
    reset = 1;
    pc = 0; fetch_valid = 1; mispredict = 0;
    upd_valid = 1; upd_pc = upc; upd_target = 32'h4000;
    upd_taken = 1; upd_is_call = 1; upd_is_ret = 0;
    @(negedge CLK);
    reset = 0;
    fetch_valid = 0; upd_valid = 0;
  endtask

  initial begin
    logic [31:0] a [1:9];
    for (int k = 1; k <= 9; k++) a[k] = 32'h2000 + 32'h10 * k + 32'h4;

    do_reset(32'h0);

    // reset state, call/ret training, aliasing
    tbl.push_back(mk("reset",    32'h100,1,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk("trcall",   32'h100,0,0, 1,32'h104,32'h400,1,1,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk("callhit",  32'h100,1,0, 0,0,0,0,0,0, 0,1,0,32'h400,0,0,0));
    tbl.push_back(mk("pushed",   32'h100,0,0, 1,32'h500,32'h108,1,0,1, 0,1,0,32'h400,0,0,32'h108));
    tbl.push_back(mk("rethit",   32'h500,1,0, 0,0,0,0,0,0, 1,0,32'h108,0,1,0,32'h108));
    tbl.push_back(mk("popped",   32'h500,0,0, 0,0,0,0,0,0, 1,0,32'h108,0,0,0,0));
    tbl.push_back(mk("alias1",   32'h100,0,0, 1,32'h100,32'h300,1,0,0, 0,1,0,32'h400,0,0,0));
    tbl.push_back(mk("alias2",   32'h100,0,0, 1,32'h200,32'h600,1,0,0, 1,1,32'h300,32'h400,0,0,0));
    tbl.push_back(mk("aliasout", 32'h100,0,0, 0,0,0,0,0,0, 0,1,0,32'h400,0,0,0));
    tbl.push_back(mk("aliasin",  32'h200,0,0, 1,32'h200,0,0,0,0, 1,0,32'h600,0,0,0,0));
    tbl.push_back(mk("invalid",  32'h200,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0));
    foreach (tbl[i]) apply(tbl[i]);

    // overflow: nine call entries, one return entry
    for (int k = 1; k <= 9; k++)
      apply(mk("trovf", 32'h200,0,0, 1,a[k]-32'h4,32'h4000,1,1,0, 0,0,0,0,0,0,0));
    apply(mk("trret", 32'h200,0,0, 1,32'h3000,32'h5000,1,0,1, 0,0,0,0,0,0,0));
    for (int k = 1; k <= 9; k++)
      apply(mk("ovfpush", a[k]-32'h4,1,0, 0,0,0,0,0,0,
               1,0,32'h4000,0,0,0,(k == 1) ? 32'h0 : a[k-1]));
    for (int j = 1; j <= 8; j++)
      apply(mk("ovfpop", 32'h3000,1,0, 0,0,0,0,0,0, 1,0,32'h5000,0,1,0,a[10-j]));
    apply(mk("ovfempty", 32'h3000,1,0, 0,0,0,0,0,0, 1,0,32'h5000,0,0,0,0));

    // reset drops the same-cycle update and clears the BTB
    do_reset(32'h2010);
    apply(mk("rstclr", 32'h2010,0,0, 1,32'h3000,32'h5000,1,0,1, 0,0,0,0,0,0,0));
    for (int k = 1; k <= 3; k++)
      apply(mk("trrec", 32'h100,0,0, 1,a[k]-32'h4,32'h4000,1,1,0, 0,0,0,0,0,0,0));
    for (int k = 1; k <= 3; k++)
      apply(mk("cpop", 32'h100,0,0, 1,32'h90fc,0,0,0,1, 0,0,0,0,0,0,0));
    apply(mk("ccall", 32'h100,0,0, 1,32'h700,0,0,1,0, 0,0,0,0,0,0,0));
    for (int k = 1; k <= 3; k++)
      apply(mk("specpush", a[k]-32'h4,1,0, 0,0,0,0,0,0,
               1,0,32'h4000,0,0,0,(k == 1) ? 32'h0 : a[k-1]));
    apply(mk("mispred", a[1]-32'h4,1,1, 1,32'h800,0,0,1,0, 1,0,32'h4000,0,0,0,a[3]));
    apply(mk("rec1", 32'h3000,1,0, 0,0,0,0,0,0, 1,0,32'h5000,0,1,0,32'h804));
    apply(mk("rec2", 32'h3000,1,0, 0,0,0,0,0,0, 1,0,32'h5000,0,1,0,32'h704));
    apply(mk("rec3", 32'h3000,0,0, 0,0,0,0,0,0, 1,0,32'h5000,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_ras_predictor.md
# btb_ras_predictor

Dual-slot branch target buffer with speculative and committed return address stacks. It answers the fetch PC's next-PC lookup each cycle. For the two instructions in the current fetch pair (pc and pc+4), it drives the hit, predicted target, return flag and return address signals that the PC register consumes. It is trained by the branch-resolution update port and repairs its speculative stack on mispredict.

## Interface
- XLEN, 32: address width.
- BTB_ENTRIES, 64: direct-mapped BTB entries; power of two.
- RAS_DEPTH, 8: entries in each return address stack; power of two.

- CLK  in  1  clock.
- reset  in  1  synchronous, active-high; clears all BTB valid bits and both stacks.
- pc  in  32  current fetch PC (signed in the PC register; treated here as raw bits). Slot 1 = pc, slot 2 = pc+4.
- fetch_valid  in  1  the fetch pair is consumed this cycle; allows speculative RAS push/pop.
- mispredict  in  1  redirect from execute; restores the speculative RAS from the committed RAS.
- upd_valid  in  1  resolved control-flow instruction update.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_target  in  XLEN  resolved taken target.
- upd_taken  in  1  instruction was taken.
- upd_is_call  in  1  instruction is a call (jal/jalr writing ra).
- upd_is_ret  in  1  instruction is a return (jalr x0, ra).
- btb_hit1, btb_hit2  out  1  slot BTB hit.
- pred_target1, pred_target2  out  XLEN  BTB target of the slot.
- is_ret1, is_ret2  out  1  slot hit is a return **and** the speculative RAS is non-empty.
- ret_addr1, ret_addr2  out  XLEN  speculative RAS top (both slots drive the same value); 0 when empty.

## Operation
- BTB entry fields: valid, tag, target, is_call, is_ret.
- BTB addressing:
  - Index = addr[log2(BTB_ENTRIES)+1:2].
  - Tag = addr[XLEN-1:log2(BTB_ENTRIES)+2].
  - Hit = valid && tag equal.
- Lookup is combinational for both slots. Outputs are meaningful only with a hit. With no hit: pred_target = 0 and is_ret = 0.
- BTB training, on upd_valid:
  - If upd_taken, write entry {1, tag, upd_target, upd_is_call, upd_is_ret} at the index, overwriting any alias.
  - If not taken and the tag matches, clear valid.
  - If not taken and the tag does not match, leave the entry unchanged.
- Selected slot: slot 1 if btb_hit1, else slot 2 if btb_hit2, else none. This matches the PC priority.
- Speculative RAS action, taken on a clock edge only when fetch_valid && !mispredict && !reset:
  - Selected slot is_call: push slotaddr+4.
  - Selected slot is_ret: pop.
  - A slot 2 hit is never acted on when slot 1 hit.
- Committed RAS action on upd_valid: upd_is_call pushes upd_pc+4; upd_is_ret pops. This happens regardless of mispredict.
- Each RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty is a no-op.
  - Pointers wrap modulo RAS_DEPTH.
- Mispredict:
  - Speculative stack contents, pointer and count are loaded from the committed stack.
  - If upd_valid occurs in the same cycle, the copy reflects the committed stack *after* that cycle's update.
  - No fetch-side RAS action occurs that cycle.
- Reset mid-operation: all state cleared on that edge, and the same-cycle update is dropped.

## Timing
- Lookup latency is 0 cycles; outputs follow pc combinationally.
- A BTB write or invalidate is visible from the cycle after upd_valid. There is no same-cycle bypass.
- A RAS push/pop is visible on ret_addr and is_ret from the next cycle.
- After reset: btb_hit1/2 = 0, pred_target1/2 = 0, is_ret1/2 = 0, ret_addr1/2 = 0, both stack counts = 0.

## Test plan
1. Reset, then pc=0x100 -> btb_hit1=btb_hit2=0, is_ret1=is_ret2=0, ret_addr1=0.
2. Train a call: upd {pc=0x104, target=0x400, taken, call}. Next cycle pc=0x100 -> btb_hit1=0, btb_hit2=1, pred_target2=0x400. On the edge with fetch_valid, the speculative stack pushes 0x108, so ret_addr1=0x108 the next cycle.
3. Train a return: upd {pc=0x500, target=0x108, taken, ret}. With the spec RAS = {0x108}, pc=0x500 -> is_ret1=1, ret_addr1=0x108. After a fetch_valid edge, the count is 0 and is_ret1=0 while pc is held at 0x500.
4. Aliasing: train 0x100->0x300, then 0x200->0x600 (same index). Lookup at 0x100 -> btb_hit1=0. Lookup at 0x200 -> pred_target1=0x600. A not-taken update at 0x200 then produces btb_hit1=0.
5. Overflow: push 9 calls with return addresses A1..A9, then 9 fetched returns. The first 8 returns yield ret_addr A9..A2. On the 9th, count=0 and is_ret forced 0.
6. Recovery: commit one call (upd_pc=0x700 -> committed top 0x704), speculatively push 3 more, then assert mispredict with simultaneous upd call at 0x800 -> next cycle spec count=2, ret_addr1=0x804.
